ff_layer_mac: RTL and testbench

FF_LAYER_MAC -- requirements
Module: ff_layer_mac

---
 rtl/ff_layer_mac.sv | 154 +++++++++++++++
 tb/tb_ff_layer_mac.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ff_layer_mac.sv
// Fully-connected layer: one signed MAC per cycle, saturating writeback, valid/ready handshakes.
// Optional FF_LAYER_RELU_EN clamps negative outputs to zero in the writeback cycle.
module ff_layer_mac #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned IN_W  = 9,
  parameter int unsigned W_W   = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned OUT_W = 17
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N_IN*IN_W-1:0]                x,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_OUT*OUT_W-1:0]              y,
  input  logic                                w_we,
  input  logic [$clog2(N_OUT*(N_IN+1))-1:0]   w_addr,
  input  logic [W_W-1:0]                      w_data,
  output logic                                busy
);

  localparam int unsigned N_COEF = N_OUT * (N_IN + 1);
  localparam int unsigned AW     = $clog2(N_COEF);
  localparam int unsigned IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned P_W    = IN_W + W_W;

  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_t;

  state_t            state_q, state_d;
  logic [W_W-1:0]    coef_q [N_COEF];
  logic [IN_W-1:0]   x_q    [N_IN];
  logic [ACC_W-1:0]  acc_q  [N_OUT];
  logic [OUT_W-1:0]  y_q    [N_OUT];
  logic [IW-1:0]     i_q;
  logic [JW-1:0]     j_q;
  logic              out_valid_q;

  logic              last_i, last_mac;
  logic [AW-1:0]     w_idx, b_idx;
  logic [W_W-1:0]    w_sel, b_sel;
  logic [IN_W-1:0]   x_sel;
  logic signed [P_W-1:0] prod;
  logic [ACC_W-1:0]  acc_base, acc_sum;

  function automatic logic [OUT_W-1:0] writeback(input logic [ACC_W-1:0] a);
    logic [OUT_W-1:0] r;
    if ($signed(a) > $signed(SAT_MAX)) begin
      r = SAT_MAX[OUT_W-1:0];
    end else if ($signed(a) < $signed(SAT_MIN)) begin
      r = SAT_MIN[OUT_W-1:0];
    end else begin
      r = a[OUT_W-1:0];
    end
`ifdef FF_LAYER_RELU_EN
    if (r[OUT_W-1]) r = '0;
`else
    r = r;
`endif
    return r;
  endfunction

  assign last_i   = (i_q == IW'(N_IN - 1));
  assign last_mac = last_i && (j_q == JW'(N_OUT - 1));

  // Coefficients are read during MAC, so a write landing on the accept edge is seen.
  always_comb begin
    w_idx    = AW'(32'(j_q) * N_IN + 32'(i_q));
    b_idx    = AW'(N_OUT * N_IN + 32'(j_q));
    w_sel    = coef_q[w_idx];
    b_sel    = coef_q[b_idx];
    x_sel    = x_q[i_q];
    prod     = $signed({{W_W{x_sel[IN_W-1]}}, x_sel}) * $signed({{IN_W{w_sel[W_W-1]}}, w_sel});
    acc_base = (i_q == '0) ? {{(ACC_W-W_W){b_sel[W_W-1]}}, b_sel} : acc_q[j_q];
    acc_sum  = acc_base + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StMac;
      StMac:   if (last_mac) state_d = StDone;
      StDone:  if (out_valid_q && out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N_COEF; k++) coef_q[k] <= '0;
      for (int k = 0; k < N_IN; k++)   x_q[k]    <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        acc_q[k] <= '0;
        y_q[k]   <= '0;
      end
      i_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (w_we && (32'(w_addr) < N_COEF)) coef_q[w_addr] <= w_data;
          if (in_valid) begin
            for (int k = 0; k < N_IN; k++) x_q[k] <= x[k*IN_W +: IN_W];
            i_q <= '0;
            j_q <= '0;
          end
        end
        StMac: begin
          acc_q[j_q] <= acc_sum;
          if (last_i) begin
            i_q <= '0;
            j_q <= last_mac ? '0 : j_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        StDone: begin
          if (!out_valid_q) begin
            for (int k = 0; k < N_OUT; k++) y_q[k] <= writeback(acc_q[k]);
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  always_comb begin
    y = '0;
    for (int k = 0; k < N_OUT; k++) y[k*OUT_W +: OUT_W] = y_q[k];
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ff_layer_mac.sv
// Randomized bench for ff_layer_mac against an arithmetic dot-product reference model.
module tb_ff_layer_mac;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 2;
  localparam int IN_W   = 9;
  localparam int OUT_W  = 17;
  localparam int N_COEF = N_OUT * (N_IN + 1);

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   in_valid, in_ready, out_valid, out_ready, w_we, busy;
  logic [N_IN*IN_W-1:0]   x;
  logic [N_OUT*OUT_W-1:0] y;
  logic [3:0]             w_addr;
  logic [7:0]             w_data;

  int n_checks = 0;
  int n_pass   = 0;
  int m_coef [N_COEF];
  int cur_x  [N_IN];

  ff_layer_mac dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .w_we(w_we),
    .w_addr(w_addr), .w_data(w_data), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint get_y(input int j);
    logic signed [OUT_W-1:0] t;
    t = y[j*OUT_W +: OUT_W];
    return longint'(t);
  endfunction

  // Bias plus dot product, wrapped to 24 bits, then clamped to the 17-bit signed range.
  function automatic longint model_y(input int j);
    longint s;
    s = m_coef[N_OUT*N_IN + j];
    for (int i = 0; i < N_IN; i++) s += longint'(cur_x[i]) * m_coef[j*N_IN + i];
    s = s & ((64'sd1 << 24) - 1);
    if (s >= (64'sd1 << 23)) s -= (64'sd1 << 24);
    if (s > 65535) s = 65535;
    if (s < -65536) s = -65536;
`ifdef FF_LAYER_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic write_coef(input int addr, input int data);
    w_we   = 1'b1;
    w_addr = addr[3:0];
    w_data = data[7:0];
    @(negedge CLK);
    w_we = 1'b0;
    if (addr < N_COEF) m_coef[addr] = data;
  endtask

  task automatic set_x();
    for (int i = 0; i < N_IN; i++) begin
      automatic int v = cur_x[i];
      x[i*IN_W +: IN_W] = v[IN_W-1:0];
    end
  endtask

  task automatic rand_x();
    for (int i = 0; i < N_IN; i++) cur_x[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  // mode 0: plain, 1: write W[0][0] mid-MAC, 2: 20-cycle output stall, 3: write on accept cycle
  task automatic run_vector(input int mode);
    longint e0, e1;
    int     k, waddr, wdata;
    set_x();
    in_valid = 1'b1;
    if (mode == 3) begin
      waddr  = int'($urandom_range(0, N_COEF - 1));
      wdata  = int'($urandom_range(0, 255)) - 128;
      w_we   = 1'b1;
      w_addr = waddr[3:0];
      w_data = wdata[7:0];
      m_coef[waddr] = wdata;
    end
    check_eq("in_ready_idle", in_ready, 1);
    e0 = model_y(0);
    e1 = model_y(1);
    @(negedge CLK);
    in_valid = 1'b0;
    w_we     = 1'b0;
    x        = '1;
    k        = 0;
    while (!out_valid && k < 40) begin
      if (mode == 1 && k == 2) begin
        w_we   = 1'b1;
        w_addr = 4'd0;
        w_data = 8'd5;
      end else begin
        w_we = 1'b0;
      end
      @(negedge CLK);
      k++;
      if (!out_valid) check_eq("busy_not_ready", {busy, in_ready}, 2'b10);
    end
    w_we = 1'b0;
    check_eq("latency", k, 9);
    check_eq("y0", get_y(0), e0);
    check_eq("y1", get_y(1), e1);
    if (mode == 2) begin
      repeat (20) begin
        in_valid = 1'b1;
        w_we     = 1'b1;
        w_addr   = 4'($urandom_range(0, 15));
        w_data   = 8'($urandom_range(0, 255));
        @(negedge CLK);
        check_eq("stall_flags", {out_valid, in_ready, busy}, 3'b101);
        check_eq("stall_y0", get_y(0), e0);
        check_eq("stall_y1", get_y(1), e1);
      end
      in_valid = 1'b0;
      w_we     = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check_eq("ov_fall", {out_valid, in_ready, busy}, 3'b010);
    check_eq("y0_retained", get_y(0), e0);
    check_eq("y1_retained", get_y(1), e1);
  endtask

  initial begin
    int seen;
    RST       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    x         = '0;
    for (int a = 0; a < N_COEF; a++) m_coef[a] = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check_eq("reset_y", longint'(y), 0);

    // Unit weights, zero bias, x = 1..4
    for (int a = 0; a < N_COEF; a++) write_coef(a, (a < N_OUT*N_IN) ? 1 : 0);
    cur_x = '{1, 2, 3, 4};
    run_vector(0);
    check_eq("unit_y0", get_y(0), 10);
    check_eq("unit_y1", get_y(1), 10);

    // Saturation in both directions, with the output held back for 20 cycles
    for (int a = 0; a < N_IN; a++) write_coef(a, 127);
    for (int a = N_IN; a < N_OUT*N_IN; a++) write_coef(a, -128);
    write_coef(N_OUT*N_IN, 127);
    write_coef(N_OUT*N_IN + 1, -128);
    cur_x = '{255, 255, 255, 255};
    run_vector(2);
    check_eq("sat_y0", get_y(0), 65535);
`ifdef FF_LAYER_RELU_EN
    check_eq("sat_y1", get_y(1), 0);
`else
    check_eq("sat_y1", get_y(1), -65536);
`endif

    // Coefficient writes outside IDLE must not take effect
    write_coef(0, 3);
    rand_x();
    cur_x[0] = 7;
    run_vector(1);
    run_vector(0);

    // Out-of-range addresses are dropped
    for (int a = N_COEF; a < 16; a++) write_coef(a, int'($urandom_range(0, 255)) - 128);
    rand_x();
    run_vector(0);

    repeat (4) begin
      rand_x();
      run_vector(3);
    end

    repeat (25) begin
      repeat ($urandom_range(0, 3)) write_coef(int'($urandom_range(0, 15)),
                                               int'($urandom_range(0, 255)) - 128);
      rand_x();
      run_vector(($urandom_range(0, 1) == 1) ? 3 : 0);
    end

    // Abort a computation with reset partway through MAC
    rand_x();
    set_x();
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    check_eq("abort_flags", {out_valid, busy}, 2'b00);
    check_eq("abort_y", longint'(y), 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int a = 0; a < N_COEF; a++) m_coef[a] = 0;
    seen = 0;
    repeat (12) begin
      @(negedge CLK);
      if (out_valid) seen = 1;
    end
    check_eq("no_stale_ov", seen, 0);
    for (int a = 0; a < N_COEF; a++) write_coef(a, 1);
    cur_x = '{1, 1, 1, 1};
    run_vector(0);
    check_eq("reload_y0", get_y(0), 5);
    check_eq("reload_y1", get_y(1), 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
